// File: rtl/atm_controller_param.sv
// ATM transaction controller with parameters for the PIN, the try limits, the balance and amount widths,
// the daily withdrawal limit and the inactivity timeout.
// Every output comes straight from a flop. A pulse output is high for one cycle, in the cycle after the
// clock edge that made the decision.
module atm_controller_param #(
  parameter int                      PIN_DIGITS = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN_CODE   = 16'h4756,
  parameter int                      WARN_TRIES = 2,
  parameter int                      MAX_TRIES  = 3,
  parameter int                      BAL_W      = 64,
  parameter int                      AMT_W      = 32,
  parameter logic [BAL_W-1:0]        INIT_BAL   = BAL_W'(4500),
  parameter logic [BAL_W-1:0]        DAY_LIMIT  = BAL_W'(2000),
  parameter int                      TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tarjeta_recibida,
  input  logic [1:0]       tipo_trans,
  input  logic             digito_stb,
  input  logic [3:0]       digito,
  input  logic             monto_stb,
  input  logic [AMT_W-1:0] monto,
  input  logic             dia_nuevo,
  output logic             balance_actualizado,
  output logic             entregar_dinero,
  output logic             pin_incorrecto,
  output logic             advertencia,
  output logic             bloqueo,
  output logic             fondos_insuficientes,
  output logic             limite_excedido,
  output logic             tiempo_agotado,
  output logic             saldo_valido,
  output logic [BAL_W-1:0] saldo
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int PIN_W = 4 * PIN_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_PIN, S_TRANS, S_LOCK} state_e;

  state_e           state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W-1:0] wd_q, wd_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  // Decision flags. The next-state logic raises them and the output logic turns them into registered pulses.
  logic ev_dep, ev_wd_ok, ev_insuf, ev_lim, ev_query, ev_bad, ev_tout;

  // Next values of the registered outputs.
  logic             upd_q, upd_d, ent_q, ent_d, bad_q, bad_d, adv_q, adv_d, blq_q, blq_d;
  logic             insuf_q, insuf_d, lim_q, lim_d, tout_q, tout_d, sv_q, sv_d;
  logic [BAL_W-1:0] saldo_q, saldo_d;

  // The arithmetic is one bit wider than the balance, so a carry or an overflow can be seen and handled.
  logic [BAL_W:0]   amt_x, dep_sum, wd_sum;
  logic [BAL_W-1:0] wd_base;

  // State register and datapath registers. The reset is synchronous and sets every register, outputs included.
  // NOTE: registers use non-blocking (<=) assignments so that every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bal_q   <= INIT_BAL;
      wd_q    <= '0;
      tries_q <= '0;
      cnt_q   <= '0;
      pin_q   <= '0;
      timer_q <= '0;
      upd_q   <= 1'b0;
      ent_q   <= 1'b0;
      bad_q   <= 1'b0;
      adv_q   <= 1'b0;
      blq_q   <= 1'b0;
      insuf_q <= 1'b0;
      lim_q   <= 1'b0;
      tout_q  <= 1'b0;
      sv_q    <= 1'b0;
      saldo_q <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      wd_q    <= wd_d;
      tries_q <= tries_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      timer_q <= timer_d;
      upd_q   <= upd_d;
      ent_q   <= ent_d;
      bad_q   <= bad_d;
      adv_q   <= adv_d;
      blq_q   <= blq_d;
      insuf_q <= insuf_d;
      lim_q   <= lim_d;
      tout_q  <= tout_d;
      sv_q    <= sv_d;
      saldo_q <= saldo_d;
    end
  end

  // Next state: PIN entry and compare, the transaction, the timeout, and the daily limit accumulator.
  // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    amt_x    = (BAL_W+1)'(monto);
    wd_base  = dia_nuevo ? '0 : wd_q;  // a new-day clear wins over a withdrawal in the same cycle
    dep_sum  = {1'b0, bal_q} + amt_x;
    wd_sum   = {1'b0, wd_base} + amt_x;
    state_d  = state_q;
    bal_d    = bal_q;
    wd_d     = wd_base;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    pin_d    = pin_q;
    timer_d  = timer_q;
    ev_dep   = 1'b0;
    ev_wd_ok = 1'b0;
    ev_insuf = 1'b0;
    ev_lim   = 1'b0;
    ev_query = 1'b0;
    ev_bad   = 1'b0;
    ev_tout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tarjeta_recibida) begin
          state_d = S_PIN;
          cnt_d   = '0;
          pin_d   = '0;
          timer_d = '0;
        end
      end
      S_PIN: begin
        if (cnt_q == CNT_W'(PIN_DIGITS)) begin
          // Compare cycle. A key pressed in this cycle is dropped.
          cnt_d   = '0;
          pin_d   = '0;
          timer_d = '0;
          if (pin_q == PIN_CODE) begin
            state_d = S_TRANS;
            tries_d = '0;
          end else begin
            ev_bad  = 1'b1;
            tries_d = tries_q + TRY_W'(1);
            if (tries_q == TRY_W'(MAX_TRIES - 1)) state_d = S_LOCK;
          end
        end else if (digito_stb && (digito <= 4'd9)) begin
          pin_d   = (pin_q << 4) | PIN_W'(digito);
          cnt_d   = cnt_q + CNT_W'(1);
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          ev_tout = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_TRANS: begin
        if (monto_stb) begin
          state_d = S_IDLE;
          timer_d = '0;
          case (tipo_trans)
            2'b00: begin
              ev_dep = 1'b1;
              bal_d  = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
            end
            2'b01: begin
              if (amt_x > {1'b0, bal_q}) begin
                ev_insuf = 1'b1;
              end else if (wd_sum > {1'b0, DAY_LIMIT}) begin
                ev_lim = 1'b1;
              end else begin
                ev_wd_ok = 1'b1;
                bal_d    = bal_q - amt_x[BAL_W-1:0];
                wd_d     = wd_sum[BAL_W-1:0];
              end
            end
            default: ev_query = 1'b1;  // the reserved code 11 is treated as a balance query
          endcase
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          ev_tout = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_LOCK: begin
        // Stays locked until reset. All inputs are ignored; only a new-day pulse still clears the accumulator.
      end
    endcase
  end

  // Output logic: the decision flags become next values for the registered pulses and levels.
  always_comb begin
    upd_d   = ev_dep | ev_wd_ok;
    ent_d   = ev_wd_ok;
    bad_d   = ev_bad;
    insuf_d = ev_insuf;
    lim_d   = ev_lim;
    tout_d  = ev_tout;
    sv_d    = ev_query;
    saldo_d = ev_query ? bal_q : saldo_q;
    adv_d   = (tries_d >= TRY_W'(WARN_TRIES));
    blq_d   = (state_d == S_LOCK);
  end

  assign balance_actualizado  = upd_q;
  assign entregar_dinero      = ent_q;
  assign pin_incorrecto       = bad_q;
  assign advertencia          = adv_q;
  assign bloqueo              = blq_q;
  assign fondos_insuficientes = insuf_q;
  assign limite_excedido      = lim_q;
  assign tiempo_agotado       = tout_q;
  assign saldo_valido         = sv_q;
  assign saldo                = saldo_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// Testbench for atm_controller_param. A transaction-level reference model checks every output on every cycle.
// Directed scenarios and randomized sessions drive the inputs. A second instance, reset to a balance near
// the top of the 64-bit range, covers deposit saturation.
module tb_atm_controller_param;

  localparam int          PIN_DIGITS = 4;
  localparam int          WARN_TRIES = 2;
  localparam int          MAX_TRIES  = 3;
  localparam int          TIMEOUT    = 255;
  localparam logic [63:0] INIT_BAL   = 64'd4500;
  localparam longint      DAY_LIMIT  = 2000;
  localparam logic [63:0] SAT_INIT   = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  int pin_seq [PIN_DIGITS] = '{4, 7, 5, 6};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic [1:0]  tipo_trans = 2'b00;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        monto_stb = 1'b0;
  logic [31:0] monto = '0;
  logic        dia_nuevo = 1'b0;

  logic        balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo;
  logic        fondos_insuficientes, limite_excedido, tiempo_agotado, saldo_valido;
  logic [63:0] saldo;
  logic        s_upd, s_ent, s_bad, s_adv, s_blq, s_insuf, s_lim, s_tout, s_sv;
  logic [63:0] s_saldo;

  always #5 clk = ~clk;

  atm_controller_param dut (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto), .dia_nuevo(dia_nuevo),
    .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
    .pin_incorrecto(pin_incorrecto), .advertencia(advertencia), .bloqueo(bloqueo),
    .fondos_insuficientes(fondos_insuficientes), .limite_excedido(limite_excedido),
    .tiempo_agotado(tiempo_agotado), .saldo_valido(saldo_valido), .saldo(saldo)
  );

  atm_controller_param #(.INIT_BAL(SAT_INIT)) u_sat (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto), .dia_nuevo(dia_nuevo),
    .balance_actualizado(s_upd), .entregar_dinero(s_ent), .pin_incorrecto(s_bad), .advertencia(s_adv),
    .bloqueo(s_blq), .fondos_insuficientes(s_insuf), .limite_excedido(s_lim), .tiempo_agotado(s_tout),
    .saldo_valido(s_sv), .saldo(s_saldo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model, written at the level of sessions: the keys entered so far are kept as a queue of digits.
  typedef enum {M_IDLE, M_PIN, M_TRANS, M_LOCK} mstate_e;
  mstate_e     m_state = M_IDLE;
  logic [63:0] m_bal;
  longint      m_wd;
  int          m_tries, m_timer;
  int          m_digits[$];
  logic        e_upd, e_ent, e_bad, e_adv, e_blq, e_insuf, e_lim, e_tout, e_sv;
  logic [63:0] e_saldo;

  task automatic model_step();
    logic [64:0] sum;
    bit          ok;
    e_upd = 0; e_ent = 0; e_bad = 0; e_insuf = 0; e_lim = 0; e_tout = 0; e_sv = 0;
    if (!rst) begin
      m_state = M_IDLE; m_bal = INIT_BAL; m_tries = 0; m_wd = 0; m_timer = 0; e_saldo = '0;
      m_digits.delete();
    end else begin
      if (dia_nuevo) m_wd = 0;
      case (m_state)
        M_IDLE: if (tarjeta_recibida) begin
          m_state = M_PIN; m_digits.delete(); m_timer = 0;
        end
        M_PIN: begin
          if (m_digits.size() == PIN_DIGITS) begin
            ok = 1;
            for (int i = 0; i < PIN_DIGITS; i++) if (m_digits[i] != pin_seq[i]) ok = 0;
            m_digits.delete(); m_timer = 0;
            if (ok) begin
              m_state = M_TRANS; m_tries = 0;
            end else begin
              e_bad = 1; m_tries++;
              if (m_tries == MAX_TRIES) m_state = M_LOCK;
            end
          end else if (digito_stb && digito <= 9) begin
            m_digits.push_back(int'(digito)); m_timer = 0;
          end else if (m_timer == TIMEOUT) begin
            m_state = M_IDLE; e_tout = 1;
          end else m_timer++;
        end
        M_TRANS: begin
          if (monto_stb) begin
            m_state = M_IDLE; m_timer = 0;
            if (tipo_trans == 2'b00) begin
              sum = {1'b0, m_bal} + 65'(monto);
              m_bal = sum[64] ? ALL_ONES : sum[63:0];
              e_upd = 1;
            end else if (tipo_trans == 2'b01) begin
              if (64'(monto) > m_bal) e_insuf = 1;
              else if (m_wd + longint'(monto) > DAY_LIMIT) e_lim = 1;
              else begin
                m_bal = m_bal - 64'(monto); m_wd = m_wd + longint'(monto); e_ent = 1; e_upd = 1;
              end
            end else begin
              e_saldo = m_bal; e_sv = 1;
            end
          end else if (m_timer == TIMEOUT) begin
            m_state = M_IDLE; e_tout = 1;
          end else m_timer++;
        end
        M_LOCK: ;
      endcase
    end
    e_adv = (m_tries >= WARN_TRIES);
    e_blq = (m_state == M_LOCK);
  endtask

  // One clock: update the model on the edge, then compare every main-instance output 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("balance_actualizado", balance_actualizado, e_upd);
    check("entregar_dinero", entregar_dinero, e_ent);
    check("pin_incorrecto", pin_incorrecto, e_bad);
    check("advertencia", advertencia, e_adv);
    check("bloqueo", bloqueo, e_blq);
    check("fondos_insuficientes", fondos_insuficientes, e_insuf);
    check("limite_excedido", limite_excedido, e_lim);
    check("tiempo_agotado", tiempo_agotado, e_tout);
    check("saldo_valido", saldo_valido, e_sv);
    check("saldo", saldo, e_saldo);
  endtask

  task automatic key(input int d);
    digito_stb = 1'b1; digito = 4'(d);
    tick();
    digito_stb = 1'b0;
  endtask

  // Insert the card, type four keys, then give the compare cycle.
  task automatic enter_pin(input int a, input int b, input int c, input int d);
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
    key(a); key(b); key(c); key(d);
    tick();
  endtask

  task automatic trans(input int t, input int amt);
    tipo_trans = 2'(t); monto = 32'(amt); monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0;
  endtask

  task automatic session(input int t, input int amt);
    enter_pin(4, 7, 5, 6);
    trans(t, amt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, d;
    bit wrong;

    // Reset state, then a withdrawal followed by a balance query.
    rst = 1'b0;
    repeat (3) tick();
    check("reset_saldo", saldo, 64'd0);
    check("reset_bloqueo", bloqueo, 0);
    rst = 1'b1;
    tick();
    session(1, 500);
    check("wd500_dispense", entregar_dinero, 1);
    check("wd500_updated", balance_actualizado, 1);
    tick();
    check("wd500_one_cycle", entregar_dinero, 0);
    session(2, 0);
    check("query_saldo_4000", saldo, 64'd4000);
    check("query_valid", saldo_valido, 1);

    // Three wrong PINs lock the machine; after that the card and keys have no effect.
    enter_pin(1, 1, 1, 1);
    check("wrong1_pulse", pin_incorrecto, 1);
    check("wrong1_adv", advertencia, 0);
    enter_pin(1, 1, 1, 1);
    check("wrong2_pulse", pin_incorrecto, 1);
    check("wrong2_adv", advertencia, 1);
    enter_pin(1, 1, 1, 1);
    check("wrong3_lock", bloqueo, 1);
    session(1, 100);
    check("locked_no_dispense", entregar_dinero, 0);
    check("locked_sticky", bloqueo, 1);

    // After reset: two wrong PINs raise the warning, and a correct PIN clears it.
    do_reset();
    enter_pin(1, 2, 3, 4);
    enter_pin(9, 9, 9, 9);
    check("adv_after_two", advertencia, 1);
    enter_pin(4, 7, 5, 6);
    check("adv_cleared", advertencia, 0);
    check("correct_no_bad", pin_incorrecto, 0);
    trans(1, 5000);
    check("insuf_pulse", fondos_insuficientes, 1);
    check("insuf_no_dispense", entregar_dinero, 0);
    check("insuf_no_update", balance_actualizado, 0);
    check("insuf_no_limit", limite_excedido, 0);
    session(2, 0);
    check("insuf_balance_kept", saldo, 64'd4500);

    // Daily limit, the new-day clear, and a new-day pulse in the same cycle as a withdrawal.
    session(1, 1500);
    check("wd1500_dispense", entregar_dinero, 1);
    session(1, 600);
    check("limit_pulse", limite_excedido, 1);
    check("limit_no_dispense", entregar_dinero, 0);
    dia_nuevo = 1'b1;
    tick();
    dia_nuevo = 1'b0;
    session(1, 600);
    check("newday_dispense", entregar_dinero, 1);
    session(2, 0);
    check("balance_2400", saldo, 64'd2400);
    session(1, 1500);
    check("limit_again", limite_excedido, 1);
    enter_pin(4, 7, 5, 6);
    dia_nuevo = 1'b1;
    trans(1, 1500);
    dia_nuevo = 1'b0;
    check("coincident_clear_dispense", entregar_dinero, 1);
    session(2, 0);
    check("balance_900", saldo, 64'd900);

    // Keys above 9 are ignored and do not count toward the PIN.
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
    key(4); key(15); key(7); key(10); key(5); key(6);
    tick();
    trans(3, 0);
    check("invalid_digits_ignored", saldo_valido, 1);

    // Timeout while waiting for the PIN, and again while waiting for the transaction.
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tiempo_agotado) n++;
    end
    check("timeout_pin_count", n, 1);
    enter_pin(4, 7, 5, 6);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tiempo_agotado) n++;
    end
    check("timeout_trans_count", n, 1);
    trans(1, 100);
    check("timeout_back_idle", entregar_dinero, 0);

    // Reset after two keys returns to IDLE.
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
    key(4); key(7);
    do_reset();
    key(5); key(6);
    tick();
    check("midpin_reset_no_compare", pin_incorrecto, 0);
    trans(1, 100);
    check("midpin_reset_idle", entregar_dinero, 0);

    // Deposit saturation on the instance whose reset balance is 2^64-3.
    session(2, 0);
    check("sat_initial", s_saldo, SAT_INIT);
    session(0, 5);
    check("sat_deposit_updated", s_upd, 1);
    session(2, 0);
    check("sat_saturated", s_saldo, ALL_ONES);
    session(0, 1);
    session(2, 0);
    check("sat_stays", s_saldo, ALL_ONES);

    // Randomized sessions, each checked against the model.
    for (int s = 0; s < 150; s++) begin
      if (m_state == M_LOCK || $urandom_range(0, 19) == 0) do_reset();
      tarjeta_recibida = 1'b1;
      tick();
      tarjeta_recibida = 1'b0;
      wrong = ($urandom_range(0, 3) == 0);
      w = int'($urandom_range(0, 3));
      for (int i = 0; i < PIN_DIGITS; i++) begin
        if ($urandom_range(0, 5) == 0) key(int'($urandom_range(10, 15)));
        d = (wrong && i == w) ? (pin_seq[i] + 1) % 10 : pin_seq[i];
        key(d);
        repeat ($urandom_range(0, 2)) tick();
      end
      digito_stb = 1'($urandom_range(0, 1));
      digito = 4'($urandom_range(0, 9));
      tick();
      digito_stb = 1'b0;
      if (m_state == M_TRANS) begin
        if ($urandom_range(0, 15) == 0) repeat (260) tick();
        repeat ($urandom_range(0, 3)) tick();
        dia_nuevo = ($urandom_range(0, 7) == 0);
        trans(int'($urandom_range(0, 3)), int'($urandom_range(0, 3000)));
        dia_nuevo = 1'b0;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
